// File: rtl/cache_refill.sv
// Single-line cache refill engine: on a miss, fetches 16 words one at a time and then writes the whole line in one strobe.
// Optional CACHE_REFILL_CRITICAL_FIRST_EN starts the fetch at the missed word and wraps around the line.
module cache_refill (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqD,
  input  logic [31:0] AdrD,
  input  logic        hit,
  output logic        stall,
  output logic        memReq,
  output logic [31:0] memAdr,
  input  logic        memAck,
  input  logic [31:0] memReadData,
  output logic        writeM,
  output logic [31:0] writeAdrM,
  output logic [31:0] writeDataM0,
  output logic [31:0] writeDataM1,
  output logic [31:0] writeDataM2,
  output logic [31:0] writeDataM3,
  output logic [31:0] writeDataM4,
  output logic [31:0] writeDataM5,
  output logic [31:0] writeDataM6,
  output logic [31:0] writeDataM7,
  output logic [31:0] writeDataM8,
  output logic [31:0] writeDataM9,
  output logic [31:0] writeDataM10,
  output logic [31:0] writeDataM11,
  output logic [31:0] writeDataM12,
  output logic [31:0] writeDataM13,
  output logic [31:0] writeDataM14,
  output logic [31:0] writeDataM15
);

  typedef enum logic [1:0] {IDLE, FETCH, FILL} state_t;

  state_t      state, state_nxt;
  logic [25:0] tag;
  logic [3:0]  idx;
  logic [3:0]  cnt;
  logic [3:0]  start_word;
  logic [31:0] wadr_last;
  logic [31:0] buffer [16];
  logic        miss;
  logic        unused_adr;

`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
  assign start_word = AdrD[5:2];
`else
  assign start_word = 4'd0;
`endif
  assign unused_adr = ^AdrD[5:0];

  assign miss  = (state == IDLE) && reqD && !hit;
  assign stall = miss || (state != IDLE);

  always_comb begin
    state_nxt = state;
    memReq    = 1'b0;
    writeM    = 1'b0;
    case (state)
      IDLE:  if (miss) state_nxt = FETCH;
      FETCH: begin
        memReq = 1'b1;
        if (memAck && cnt == 4'd15) state_nxt = FILL;
      end
      FILL: begin
        writeM    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign memAdr    = memReq ? {tag, idx, 2'b00} : 32'd0;
  assign writeAdrM = writeM ? {tag, 6'b0} : wadr_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tag       <= '0;
      idx       <= '0;
      cnt       <= '0;
      wadr_last <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (miss) begin
          tag <= AdrD[31:6];
          idx <= start_word;
          cnt <= 4'd0;
        end
        FETCH: if (memAck) begin
          idx <= idx + 4'd1;
          cnt <= cnt + 4'd1;
        end
        FILL: wadr_last <= {tag, 6'b0};
        default: ;
      endcase
    end
  end

  // Buffer slot is the word's position in the line, independent of fetch order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) buffer[i] <= '0;
    end else if (state == FETCH && memAck) begin
      buffer[idx] <= memReadData;
    end
  end

  assign writeDataM0  = buffer[0];
  assign writeDataM1  = buffer[1];
  assign writeDataM2  = buffer[2];
  assign writeDataM3  = buffer[3];
  assign writeDataM4  = buffer[4];
  assign writeDataM5  = buffer[5];
  assign writeDataM6  = buffer[6];
  assign writeDataM7  = buffer[7];
  assign writeDataM8  = buffer[8];
  assign writeDataM9  = buffer[9];
  assign writeDataM10 = buffer[10];
  assign writeDataM11 = buffer[11];
  assign writeDataM12 = buffer[12];
  assign writeDataM13 = buffer[13];
  assign writeDataM14 = buffer[14];
  assign writeDataM15 = buffer[15];

endmodule

// File: tb/tb_cache_refill.sv
// Directed bench for cache_refill: reset, hit, back-to-back and wait-state refills, mid-fetch reset and ignored inputs.
module tb_cache_refill;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqD;
  logic [31:0] AdrD;
  logic        hit;
  logic        stall;
  logic        memReq;
  logic [31:0] memAdr;
  logic        memAck;
  logic [31:0] memReadData;
  logic        writeM;
  logic [31:0] writeAdrM;
  logic [31:0] wd [16];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cache_refill dut (
    .clk(clk), .reset(reset), .reqD(reqD), .AdrD(AdrD), .hit(hit),
    .stall(stall), .memReq(memReq), .memAdr(memAdr), .memAck(memAck),
    .memReadData(memReadData), .writeM(writeM), .writeAdrM(writeAdrM),
    .writeDataM0(wd[0]),   .writeDataM1(wd[1]),   .writeDataM2(wd[2]),   .writeDataM3(wd[3]),
    .writeDataM4(wd[4]),   .writeDataM5(wd[5]),   .writeDataM6(wd[6]),   .writeDataM7(wd[7]),
    .writeDataM8(wd[8]),   .writeDataM9(wd[9]),   .writeDataM10(wd[10]), .writeDataM11(wd[11]),
    .writeDataM12(wd[12]), .writeDataM13(wd[13]), .writeDataM14(wd[14]), .writeDataM15(wd[15])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives a miss at adr and services every word after `waits` idle cycles.
  task automatic refill(input logic [31:0] adr, input int waits, input bit move_adr);
    logic [3:0]  start;
    logic [31:0] exp;
    int          cyc;
`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
    start = adr[5:2];
`else
    start = 4'd0;
`endif
    @(negedge clk);
    reqD = 1'b1; hit = 1'b0; AdrD = adr; memAck = 1'b0;
    #1 check("miss_stall", {31'd0, stall}, 32'd1);
    cyc = 0;
    for (int k = 0; k < 16; k++) begin
      exp = {adr[31:6], 4'(start + 4'(k)), 2'b00};
      for (int w = 0; w <= waits; w++) begin
        @(negedge clk);
        cyc++;
        if (move_adr && k == 8) AdrD = 32'h0000_9000;
        memAck      = (w == waits);
        memReadData = memAck ? exp : 32'hDEAD_BEEF;
        #1;
        check("fetch_req",   {31'd0, memReq}, 32'd1);
        check("fetch_adr",   memAdr, exp);
        check("fetch_wm",    {31'd0, writeM}, 32'd0);
        check("fetch_stall", {31'd0, stall}, 32'd1);
      end
    end
    @(negedge clk);
    cyc++;
    memAck = 1'b0;
    #1;
    check("fill_cycle", 32'(cyc), 32'(17 + 16 * waits));
    check("fill_wm",    {31'd0, writeM}, 32'd1);
    check("fill_req",   {31'd0, memReq}, 32'd0);
    check("fill_wadr",  writeAdrM, {adr[31:6], 6'b0});
    check("fill_stall", {31'd0, stall}, 32'd1);
    hit = 1'b1;
    @(negedge clk);
    #1;
    check("done_stall", {31'd0, stall}, 32'd0);
    check("done_wm",    {31'd0, writeM}, 32'd0);
    check("done_req",   {31'd0, memReq}, 32'd0);
    check("done_wadr",  writeAdrM, {adr[31:6], 6'b0});
    for (int i = 0; i < 16; i++)
      check("line_word", wd[i], {adr[31:6], 4'(i), 2'b00});
    reqD = 1'b0;
  endtask

  initial begin
    reset = 1'b0; reqD = 1'b0; AdrD = '0; hit = 1'b0; memAck = 1'b0; memReadData = '0;
    #1;
    check("rst_req",   {31'd0, memReq}, 32'd0);
    check("rst_wm",    {31'd0, writeM}, 32'd0);
    check("rst_adr",   memAdr, 32'd0);
    check("rst_wadr",  writeAdrM, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_wd0",   wd[0], 32'd0);
    check("rst_wd15",  wd[15], 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Hits never start a refill.
    reqD = 1'b1; hit = 1'b1; AdrD = 32'h0000_1040;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check("hit_stall", {31'd0, stall}, 32'd0);
      check("hit_req",   {31'd0, memReq}, 32'd0);
    end
    reqD = 1'b0;

    refill(32'h0000_1040, 0, 1'b0);
    check("wd5", wd[5], 32'h0000_1054);
    refill(32'h0000_1040, 2, 1'b0);
    refill(32'h0000_2038, 0, 1'b0);

    // Acknowledge with no request pending.
    @(negedge clk);
    reqD = 1'b0; memAck = 1'b1; memReadData = 32'h1234_5678;
    #1;
    check("spur_req",   {31'd0, memReq}, 32'd0);
    check("spur_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    memAck = 1'b0;
    #1;
    check("spur_stall2", {31'd0, stall}, 32'd0);
    check("spur_wd0",    wd[0], 32'h0000_2000);

    refill(32'h0000_4000, 0, 1'b1);

    // Reset lands on the 8th acknowledge of a refill.
    @(negedge clk);
    reqD = 1'b1; hit = 1'b0; AdrD = 32'h0000_5000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      memAck = 1'b1; memReadData = 32'h0000_5000 + 32'(4 * k);
      #1 check("abort_adr", memAdr, 32'h0000_5000 + 32'(4 * k));
    end
    reset = 1'b0; reqD = 1'b0;
    #1;
    check("abort_req",   {31'd0, memReq}, 32'd0);
    check("abort_adr0",  memAdr, 32'd0);
    check("abort_wm",    {31'd0, writeM}, 32'd0);
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_wadr",  writeAdrM, 32'd0);
    check("abort_wd3",   wd[3], 32'd0);
    @(negedge clk);
    reset = 1'b1; memAck = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      check("post_abort_wm",  {31'd0, writeM}, 32'd0);
      check("post_abort_req", {31'd0, memReq}, 32'd0);
    end
    refill(32'h0000_3000, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_refill.md
CACHE_REFILL -- requirements
Module: cache_refill

Interface
REQ-001 Parameters: none; the line is fixed at 16 words of 32 bits, 64 bytes, with tag = address[31:6].
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 reqD  input  1  core access (load or store) valid this cycle.
REQ-005 AdrD  input  32  core byte address.
REQ-006 hit  input  1  hit indication from the single-line cache.
REQ-007 stall  output  1  core must hold its request; high while a refill is pending.
REQ-008 memReq  output  1  word read request to main memory.
REQ-009 memAdr  output  32  word-aligned memory read address.
REQ-010 memAck  input  1  memory returns memReadData for the current memAdr this cycle.
REQ-011 memReadData  input  32  memory read word.
REQ-012 writeM  output  1  one-cycle line-fill strobe to the cache.
REQ-013 writeAdrM  output  32  line base address {tag, 6'b0}.
REQ-014 writeDataM0..writeDataM15  output  32 each  assembled line words; word i = byte offset 4*i.

Function
REQ-015 FSM states: IDLE, FETCH, FILL; encoding is free.
REQ-016 stall = (IDLE and reqD and !hit) or state != IDLE; combinational.
REQ-017 IDLE with reqD and !hit: the edge latches tag = AdrD[31:6], idx = start word, cnt = 0, and moves to FETCH.
REQ-018 AdrD/reqD changes while state != IDLE are ignored; the latched tag governs the refill.
REQ-019 FETCH: memReq = 1; memAdr = {tag, idx, 2'b00}; memAdr is stable until memAck.
REQ-020 FETCH with memAck: the edge writes memReadData into buffer[idx], sets idx = (idx+1) mod 16 and cnt = cnt+1.
REQ-021 On that edge, if cnt was 15, the FSM moves to FILL; otherwise it stays in FETCH and the next address appears the next cycle.
REQ-022 memAck with memReq low is ignored; exactly one outstanding word request; wait states are unbounded.
REQ-023 FILL: writeM = 1 for exactly one cycle; writeAdrM = {tag, 6'b0}; the FSM moves to IDLE on the next edge.
REQ-024 writeDataMi = buffer[i] at all times; writeAdrM holds its last value outside FILL.
REQ-025 Latency with memAck every cycle: miss seen in cycle 0; FETCH in cycles 1-16; FILL in cycle 17; cache hit and stall low in cycle 18.
REQ-026 Each memory wait cycle adds one cycle to REQ-025.
REQ-027 A hit in IDLE produces no memory traffic and no stall.
REQ-028 memReq and writeM are never high in the same cycle.

Reset
REQ-029 Asserting reset asynchronously forces IDLE, and clears idx, cnt, tag and all buffer words to 0.
REQ-030 Reset values: memReq = 0, writeM = 0, memAdr = 0, writeAdrM = 0, writeDataM0..15 = 0; stall follows REQ-016.
REQ-031 Reset mid-FETCH or mid-FILL aborts immediately; no writeM pulse is issued for the aborted line.
REQ-032 Deassertion is synchronised externally; the first active edge after deassertion behaves as IDLE.

Configuration
REQ-033 Macro CACHE_REFILL_CRITICAL_FIRST_EN defined: start word = AdrD[5:2] and fetch wraps 15 -> 0 until all 16 words are fetched.
REQ-034 Macro CACHE_REFILL_CRITICAL_FIRST_EN undefined: start word = 0; fetch order is 0..15.
REQ-035 Macro CACHE_REFILL_CRITICAL_FIRST_EN does not change latency, the writeM timing or the buffer positions of words.

Verification
REQ-036 Reset low -> all outputs 0 and the FSM in IDLE; reset high then reqD=1, hit=1 -> stall=0 and memReq never asserts.
REQ-037 Miss at AdrD=0x0000_1040, memAck every cycle, memReadData=memAdr -> memAdr 0x1040..0x107C in order; writeM in cycle 17 only; writeAdrM=0x1040; writeDataM5=0x1054.
REQ-038 Repeat REQ-037 with 2 wait cycles before each memAck -> FILL in cycle 49; memAdr is stable during the waits; stall is high throughout.
REQ-039 With the macro defined, miss at AdrD=0x0000_2038 -> memAdr order 0x2038..0x203C, then 0x2000..0x2034; line contents are identical to the undefined-macro run.
REQ-040 Reset pulsed low at the 8th memAck -> memReq drops at once and writeM never pulses; a subsequent miss to 0x3000 refills cleanly from word 0.
REQ-041 Spurious memAck in IDLE, and AdrD changed to 0x9000 mid-FETCH -> both ignored; the fill completes for the originally latched tag.
